// File: rtl/processing_unit_gen.sv
`default_nettype none
// ============================================================================
//  Module      : processing_unit_gen
//  Description : NoC node processing unit. On a user start it requests the
//                master arbiter, and once granted emits one burst packet of
//                burst_len flits toward the latched destination processor.
//                Payload is either the 1-based flit index or an LFSR
//                sequence. The MSB of every flit is the tlast marker.
//                A receive-side monitor counts incoming flits and packets
//                with saturating counters.
//  Ports       : clock, reset              - clock, async active-high reset
//                start, dest, burst_len,
//                mode                      - packet request from the user
//                master_response           - grant from the master arbiter
//                request_transfer,
//                which_processor           - registered request to master
//                processor_ready           - high while idle
//                data_to_router, flit_valid- outgoing flit stream
//                data_from_router, rx_valid- incoming flit stream
//                rx_flit_count,
//                rx_pkt_count              - saturating receive counters
//  Revision    : 1.0 - initial release
// ============================================================================
module processing_unit_gen #(
   parameter int                DATA_W    = 8,
   parameter int                LEN_W     = 8,
   parameter int                DEST_W    = 2,
   parameter int                CNT_W     = 16,
   parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
   parameter logic [DATA_W-1:0] LFSR_SEED = 8'h01
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [DEST_W-1:0] dest,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              mode,
   input  logic              master_response,
   output logic              request_transfer,
   output logic [DEST_W-1:0] which_processor,
   output logic              processor_ready,
   output logic [DATA_W:0]   data_to_router,
   output logic              flit_valid,
   input  logic [DATA_W:0]   data_from_router,
   input  logic              rx_valid,
   output logic [CNT_W-1:0]  rx_flit_count,
   output logic [CNT_W-1:0]  rx_pkt_count
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_SEND = 2'd2;

   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic [1:0]        r_state;
   logic [LEN_W-1:0]  r_len;
   logic              r_mode;
   logic [LEN_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_lfsr;
   logic              r_req;
   logic [DEST_W-1:0] r_dest;
   logic [DATA_W:0]   r_data;
   logic              r_flit_valid;
   logic [CNT_W-1:0]  r_rx_flits;
   logic [CNT_W-1:0]  r_rx_pkts;

   logic [DATA_W-1:0] w_cnt_payload;
   logic [DATA_W-1:0] w_lfsr_next;
   logic              w_last;
   logic              w_done;

   // Counter payload is the flit index resized to the payload width.
   assign w_cnt_payload = DATA_W'(r_idx);
   assign w_lfsr_next   = {r_lfsr[DATA_W-2:0], ^(r_lfsr & LFSR_TAPS)};
   assign w_last        = (r_idx == r_len);
   // The flit currently on the output was the tlast flit: packet complete.
   assign w_done        = r_flit_valid & r_data[DATA_W];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_mode       <= 1'b0;
         r_idx        <= LEN_W'(1);
         r_lfsr       <= LFSR_SEED;
         r_req        <= 1'b0;
         r_dest       <= '0;
         r_data       <= '0;
         r_flit_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && (burst_len != '0)) begin
                  r_len   <= burst_len;
                  r_mode  <= mode;
                  r_dest  <= dest;
                  r_req   <= 1'b1;
                  r_state <= S_REQ;
               end
            end
            S_REQ: begin
               if (master_response) begin
                  r_req   <= 1'b0;
                  r_idx   <= LEN_W'(1);
                  r_lfsr  <= LFSR_SEED;
                  r_state <= S_SEND;
               end
            end
            S_SEND: begin
               if (w_done) begin
                  r_flit_valid <= 1'b0;
                  r_data       <= '0;
                  r_state      <= S_IDLE;
               end else begin
                  r_flit_valid <= 1'b1;
                  r_data       <= {w_last, (r_mode ? r_lfsr : w_cnt_payload)};
                  r_idx        <= r_idx + LEN_W'(1);
                  r_lfsr       <= w_lfsr_next;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_req        <= 1'b0;
               r_flit_valid <= 1'b0;
               r_data       <= '0;
            end
         endcase
      end
   end

   // Receive monitor, independent of the transmit FSM.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rx_flits <= '0;
         r_rx_pkts  <= '0;
      end else if (rx_valid) begin
         if (r_rx_flits != c_CNT_MAX) begin
            r_rx_flits <= r_rx_flits + CNT_W'(1);
         end
         if (data_from_router[DATA_W] && (r_rx_pkts != c_CNT_MAX)) begin
            r_rx_pkts <= r_rx_pkts + CNT_W'(1);
         end
      end
   end

   assign request_transfer = r_req;
   assign which_processor  = r_dest;
   assign processor_ready  = (r_state == S_IDLE);
   assign data_to_router   = r_data;
   assign flit_valid       = r_flit_valid;
   assign rx_flit_count    = r_rx_flits;
   assign rx_pkt_count     = r_rx_pkts;

endmodule
`default_nettype wire

// File: tb/tb_processing_unit_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_processing_unit_gen
//  Description : Self-checking bench for processing_unit_gen. Table-driven
//                packets with hand-computed end flits, randomized packets
//                and randomized receive traffic checked against a
//                behavioural model, plus hand sequences for zero length,
//                back-to-back, mid-burst reset and counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_processing_unit_gen;

   localparam int DW = 8;

   logic          clock;
   logic          reset;
   logic          start;
   logic [1:0]    dest;
   logic [7:0]    burst_len;
   logic          mode;
   logic          master_response;
   logic          request_transfer;
   logic [1:0]    which_processor;
   logic          processor_ready;
   logic [DW:0]   data_to_router;
   logic          flit_valid;
   logic [DW:0]   data_from_router;
   logic          rx_valid;
   logic [15:0]   rx_flit_count;
   logic [15:0]   rx_pkt_count;

   // Second instance with narrow receive counters for saturation.
   logic          s_req;
   logic [1:0]    s_which;
   logic          s_ready;
   logic [DW:0]   s_data;
   logic          s_valid;
   logic [1:0]    s_flits;
   logic [1:0]    s_pkts;

   processing_unit_gen u_dut (
      .clock(clock), .reset(reset), .start(start), .dest(dest),
      .burst_len(burst_len), .mode(mode), .master_response(master_response),
      .request_transfer(request_transfer), .which_processor(which_processor),
      .processor_ready(processor_ready), .data_to_router(data_to_router),
      .flit_valid(flit_valid), .data_from_router(data_from_router),
      .rx_valid(rx_valid), .rx_flit_count(rx_flit_count),
      .rx_pkt_count(rx_pkt_count)
   );

   processing_unit_gen #(.CNT_W(2)) u_dut_sat (
      .clock(clock), .reset(reset), .start(1'b0), .dest(2'd0),
      .burst_len(8'd0), .mode(1'b0), .master_response(1'b0),
      .request_transfer(s_req), .which_processor(s_which),
      .processor_ready(s_ready), .data_to_router(s_data),
      .flit_valid(s_valid), .data_from_router(data_from_router),
      .rx_valid(rx_valid), .rx_flit_count(s_flits),
      .rx_pkt_count(s_pkts)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_vec = 0;
   int n_err = 0;
   int m_flits = 0, m_pkts = 0, ms_flits = 0, ms_pkts = 0;
   bit rx_rand = 1'b0;

   typedef struct {
      logic [1:0] d;
      int         len;
      bit         md;
      int         gdel;
      logic [8:0] first;
      logic [8:0] last;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock edge; the receive model counts what the DUT sampled.
   task automatic tick();
      bit v, t;
      v = rx_valid;
      t = data_from_router[DW];
      @(posedge clock);
      if (!reset && v) begin
         if (m_flits < 65535) m_flits++;
         if (t && m_pkts < 65535) m_pkts++;
         if (ms_flits < 3) ms_flits++;
         if (t && ms_pkts < 3) ms_pkts++;
      end
      #1;
      if (rx_rand) begin
         rx_valid         = 1'($urandom);
         data_from_router = 9'($urandom);
      end
   endtask

   task automatic zero_model();
      m_flits = 0; m_pkts = 0; ms_flits = 0; ms_pkts = 0;
   endtask

   task automatic chk_rx();
      chk("rx_flit_count", 32'(rx_flit_count), m_flits);
      chk("rx_pkt_count", 32'(rx_pkt_count), m_pkts);
      chk("sat_flit_count", 32'(s_flits), ms_flits);
      chk("sat_pkt_count", 32'(s_pkts), ms_pkts);
   endtask

   // Expected flit i (1-based) of a packet, from the payload rules.
   function automatic logic [8:0] exp_flit(input int len, input bit md, input int i);
      logic [7:0] l;
      logic [7:0] p;
      l = 8'h01;
      for (int k = 1; k < i; k++) l = {l[6:0], ^(l & 8'hB8)};
      p = md ? l : 8'(i % 256);
      return {(i == len), p};
   endfunction

   task automatic send_pkt(input logic [1:0] d, input int len, input bit md, input int gdel,
                           input bit ends, input logic [8:0] f, input logic [8:0] l);
      chk("ready_before", 32'(processor_ready), 1);
      start = 1'b1; dest = d; burst_len = len[7:0]; mode = md;
      tick();
      start = 1'b0; dest = 2'($urandom); burst_len = 8'($urandom); mode = 1'($urandom);
      chk("req_set", 32'(request_transfer), 1);
      chk("which_proc", 32'(which_processor), 32'(d));
      chk("ready_low", 32'(processor_ready), 0);
      for (int k = 0; k < gdel; k++) begin
         master_response = 1'b0;
         tick();
         chk("req_hold", 32'(request_transfer), 1);
         chk("which_hold", 32'(which_processor), 32'(d));
      end
      master_response = 1'b1;
      tick();
      master_response = 1'b0;
      chk("req_drop", 32'(request_transfer), 0);
      chk("no_flit_at_grant", 32'(flit_valid), 0);
      for (int i = 1; i <= len; i++) begin
         start = 1'($urandom); master_response = 1'($urandom);
         tick();
         chk("flit_valid", 32'(flit_valid), 1);
         chk("flit_data", 32'(data_to_router), 32'(exp_flit(len, md, i)));
         if (ends && i == 1)   chk("tbl_first", 32'(data_to_router), 32'(f));
         if (ends && i == len) chk("tbl_last", 32'(data_to_router), 32'(l));
      end
      start = 1'($urandom); master_response = 1'($urandom);
      tick();
      start = 1'b0; master_response = 1'b0;
      chk("end_valid", 32'(flit_valid), 0);
      chk("end_data", 32'(data_to_router), 0);
      chk("end_ready", 32'(processor_ready), 1);
      tick();
      chk("no_queued_start", 32'(request_transfer), 0);
      chk_rx();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{2'd2,   3, 1'b0, 2, 9'h001, 9'h103};
      tbl[1] = '{2'd1,   4, 1'b1, 0, 9'h001, 9'h108};
      tbl[2] = '{2'd3,   1, 1'b0, 1, 9'h101, 9'h101};
      tbl[3] = '{2'd0,   1, 1'b1, 3, 9'h101, 9'h101};
      tbl[4] = '{2'd2,   5, 1'b1, 1, 9'h001, 9'h111};
      tbl[5] = '{2'd0,   5, 1'b0, 0, 9'h001, 9'h105};
      tbl[6] = '{2'd1, 255, 1'b0, 2, 9'h001, 9'h1FF};

      reset = 1'b1; start = 1'b0; dest = '0; burst_len = '0; mode = 1'b0;
      master_response = 1'b0; rx_valid = 1'b0; data_from_router = '0;
      tick(); tick();
      chk("rst_req", 32'(request_transfer), 0);
      chk("rst_which", 32'(which_processor), 0);
      chk("rst_ready", 32'(processor_ready), 1);
      chk("rst_data", 32'(data_to_router), 0);
      chk("rst_valid", 32'(flit_valid), 0);
      chk_rx();
      reset = 1'b0;
      tick();

      // Receive: tlast on flits 3 and 5, then a sixth plain flit.
      for (int i = 1; i <= 6; i++) begin
         rx_valid = 1'b1;
         data_from_router = {(i == 3 || i == 5), 8'(i)};
         tick();
         if (i == 5) begin
            chk("rx5_flits", 32'(rx_flit_count), 5);
            chk("rx5_pkts", 32'(rx_pkt_count), 2);
         end
      end
      rx_valid = 1'b0;
      tick();
      chk("sat_flits_3", 32'(s_flits), 3);
      chk("sat_pkts_2", 32'(s_pkts), 2);
      chk_rx();
      rx_rand = 1'b1;

      foreach (tbl[i])
         send_pkt(tbl[i].d, tbl[i].len, tbl[i].md, tbl[i].gdel, 1'b1, tbl[i].first, tbl[i].last);

      // Zero length start is ignored.
      start = 1'b1; burst_len = 8'd0; dest = 2'd3;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("len0_no_req", 32'(request_transfer), 0);
         chk("len0_ready", 32'(processor_ready), 1);
      end
      start = 1'b0;

      // Back-to-back: start held high through the packet.
      start = 1'b1; dest = 2'd1; burst_len = 8'd1; mode = 1'b0;
      tick();
      chk("b2b_req1", 32'(request_transfer), 1);
      master_response = 1'b1; tick(); master_response = 1'b0;
      tick();
      chk("b2b_flit", 32'(data_to_router), 32'h101);
      tick();
      chk("b2b_ready", 32'(processor_ready), 1);
      tick();
      chk("b2b_req2", 32'(request_transfer), 1);
      start = 1'b0;
      master_response = 1'b1; tick(); master_response = 1'b0;
      tick();
      chk("b2b_flit2", 32'(data_to_router), 32'h101);
      tick();
      tick();
      chk("b2b_idle", 32'(request_transfer), 0);

      // Reset during flit 2 of a length-5 packet.
      start = 1'b1; dest = 2'd3; burst_len = 8'd5; mode = 1'b0;
      tick();
      start = 1'b0;
      master_response = 1'b1; tick(); master_response = 1'b0;
      tick(); tick();
      chk("mid_flit2", 32'(data_to_router), 32'h002);
      #2;
      reset = 1'b1;
      zero_model();
      #1;
      chk("arst_req", 32'(request_transfer), 0);
      chk("arst_which", 32'(which_processor), 0);
      chk("arst_ready", 32'(processor_ready), 1);
      chk("arst_data", 32'(data_to_router), 0);
      chk("arst_valid", 32'(flit_valid), 0);
      chk_rx();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("abandoned_valid", 32'(flit_valid), 0);
         chk("abandoned_data", 32'(data_to_router), 0);
      end
      send_pkt(2'd2, 3, 1'b0, 1, 1'b1, 9'h001, 9'h103);

      // Randomized packets against the model.
      for (int n = 0; n < 15; n++)
         send_pkt(2'($urandom), int'($urandom_range(1, 16)), 1'($urandom),
                  int'($urandom_range(0, 3)), 1'b0, 9'h0, 9'h0);
      send_pkt(2'd3, 200, 1'b1, 0, 1'b0, 9'h0, 9'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/processing_unit_gen.md
Name: processing_unit_gen

Overview:
Parametrised successor of the per-node processing unit in the NoC. Generates one burst packet per request toward a selected destination processor. Each packet carries a counter or LFSR payload, with an MSB last-flit marker on each flit. Uses the same request/master_response handshake toward the master arbiter, and adds a receive-side monitor that counts flits and packets arriving from the local router.

Parameters:
DATA_W, 8, payload bits per flit; flit width is DATA_W+1 (MSB = tlast)
LEN_W, 8, burst length counter width
DEST_W, 2, destination processor index width
CNT_W, 16, receive counter width
LFSR_TAPS, 8'hB8, feedback tap mask (DATA_W bits) for LFSR mode
LFSR_SEED, 8'h01, nonzero LFSR seed, reloaded at every packet start

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  user request to send one packet
dest  in  DEST_W  destination processor for the packet
burst_len  in  LEN_W  flits in the packet (0 = invalid)
mode  in  1  payload mode: 0 = counter, 1 = LFSR
master_response  in  1  master has granted this processor
request_transfer  out  1  request to master, registered
which_processor  out  DEST_W  latched destination, registered
processor_ready  out  1  high in IDLE, able to accept start
data_to_router  out  DATA_W+1  {tlast, payload}, registered
flit_valid  out  1  data_to_router holds a valid flit this cycle
data_from_router  in  DATA_W+1  incoming flit {tlast, payload}
rx_valid  in  1  data_from_router valid this cycle
rx_flit_count  out  CNT_W  flits received, saturating
rx_pkt_count  out  CNT_W  flits received with tlast=1, saturating

Behaviour:
- Reset (async, any state): FSM to IDLE; processor_ready=1; request_transfer=0; which_processor=0; data_to_router=0; flit_valid=0; rx counts=0; LFSR=LFSR_SEED; flit index=1. A reset mid-burst abandons the packet; no tlast is emitted.
- FSM states: IDLE, REQ, SEND.
- IDLE:
  - On start=1 with burst_len!=0, latch dest, burst_len and mode.
  - Next edge: request_transfer=1, which_processor=dest, processor_ready=0, state=REQ.
  - start with burst_len=0 is ignored and the FSM stays in IDLE.
- REQ:
  - Hold request_transfer=1 and which_processor stable until master_response=1.
  - On the edge where master_response=1 is sampled: request_transfer=0, state=SEND, flit index=1, LFSR=LFSR_SEED.
- SEND:
  - One flit per cycle with flit_valid=1; no backpressure.
  - First flit appears on the first edge after entering SEND.
  - Payload in counter mode: flit index (1-based) truncated to DATA_W.
  - Payload in LFSR mode: current LFSR value; the first flit is LFSR_SEED. LFSR advances lfsr <= {lfsr[DATA_W-2:0], ^(lfsr & LFSR_TAPS)} per flit.
  - tlast = (flit index == latched len). The tlast flit is the last flit; the next edge gives flit_valid=0, data_to_router=0, state=IDLE, processor_ready=1.
  - Packet of length N occupies exactly N cycles of flit_valid.
- Ignored inputs:
  - start outside IDLE is ignored and not queued.
  - master_response in IDLE or SEND is ignored.
  - dest, burst_len and mode changes after latching have no effect on the current packet.
- Back-to-back packets: start held high in IDLE issues a new request the cycle after returning to IDLE.
- Length wrap: burst_len = 2^LEN_W-1 is legal; the index never wraps within a packet.
- Receive monitor, independent of the FSM:
  - Each rx_valid=1 cycle increments rx_flit_count.
  - rx_pkt_count also increments if data_from_router[DATA_W]=1.
  - Both counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Reset, then start=1, dest=2, len=3, mode=0; master_response pulses 2 cycles later -> request_transfer high until the grant edge, which_processor=2; flits 0x001, 0x002, 0x103 on 3 consecutive cycles; processor_ready returns to 1.
- mode=1, len=4, default taps/seed -> payloads 0x01, 0x02, 0x04, 0x08, tlast only on the 4th flit.
- start with burst_len=0 -> no request, processor_ready stays 1; start pulsed during SEND -> ignored, only one packet sent.
- Assert reset during flit 2 of a len=5 packet -> all outputs immediately at reset values, no tlast seen, next start works normally.
- Drive 5 rx flits with tlast on the 3rd and 5th -> rx_flit_count=5, rx_pkt_count=2; with CNT_W=2 drive 6 flits -> rx_flit_count saturates at 3.
